// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the iterative divider: func3 codes, FSM encoding,
// iteration count and the final sign/special-case result selection.
package rv32_pkg;

  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6;
  localparam logic [2:0] F3_REMU = 3'd7;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Divide-by-zero and signed overflow take the RISC-V defined values
  // regardless of what the magnitude datapath produced.
  function automatic logic [31:0] div_fix(
    input logic        is_rem,
    input logic        neg_q,
    input logic        neg_r,
    input logic        div0,
    input logic        ovf,
    input logic [31:0] q_mag,
    input logic [31:0] r_mag,
    input logic [31:0] a_raw
  );
    logic [31:0] res;
    if (div0)
      res = is_rem ? a_raw : 32'hFFFF_FFFF;
    else if (ovf)
      res = is_rem ? 32'd0 : 32'h8000_0000;
    else if (is_rem)
      res = neg_r ? (~r_mag + 32'd1) : r_mag;
    else
      res = neg_q ? (~q_mag + 32'd1) : q_mag;
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in the next dividend bit and keep
// the difference only when the 33-bit trial value covers the divisor.
module div_step (
  input  logic [31:0] rem_in,
  input  logic [31:0] divisor,
  input  logic        dvd_bit,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [32:0] trial;
  logic [32:0] diff;

  assign trial = {rem_in, dvd_bit};
  assign diff  = trial - {1'b0, divisor};
  assign q_bit = (trial >= {1'b0, divisor});
  // When the bit is 0 the trial is below the divisor, so it fits in 32 bits.
  assign rem_out = q_bit ? diff[31:0] : trial[31:0];

endmodule

// File: rtl/div_unit_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit_iter
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_t  state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] rem_reg;
  logic [31:0] dvd_reg;
  logic [31:0] dvs_reg;
  logic [31:0] a_reg;
  logic        is_rem_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic        div0_reg;
  logic        ovf_reg;

  logic        is_signed;
  logic        is_rem;
  logic        sgn_a;
  logic        sgn_b;
  logic        div0_in;
  logic        ovf_in;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] rem_next;
  logic        q_bit;
  logic [31:0] quo_next;

  assign is_signed = (func3 == F3_DIV) || (func3 == F3_REM);
  assign is_rem    = (func3 == F3_REM) || (func3 == F3_REMU);
  assign sgn_a     = is_signed & a[31];
  assign sgn_b     = is_signed & b[31];
  assign mag_a     = sgn_a ? (~a + 32'd1) : a;
  assign mag_b     = sgn_b ? (~b + 32'd1) : b;
  assign div0_in   = (b == 32'd0);
  assign ovf_in    = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // The dividend register doubles as the quotient: bits leave at the top
  // while quotient bits enter at the bottom.
  div_step u_step (
    .rem_in  (rem_reg),
    .divisor (dvs_reg),
    .dvd_bit (dvd_reg[31]),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign quo_next = {dvd_reg[30:0], q_bit};
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 5'd0;
      rem_reg    <= 32'd0;
      dvd_reg    <= 32'd0;
      dvs_reg    <= 32'd0;
      a_reg      <= 32'd0;
      is_rem_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      done       <= 1'b0;
      result     <= 32'd0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              rem_reg    <= 32'd0;
              dvd_reg    <= mag_a;
              dvs_reg    <= mag_b;
              a_reg      <= a;
              is_rem_reg <= is_rem;
              neg_q_reg  <= sgn_a ^ sgn_b;
              neg_r_reg  <= sgn_a;
              div0_reg   <= div0_in;
              ovf_reg    <= ovf_in;
              cnt_reg    <= 5'(DIV_ITERS - 1);
`ifdef DIV_FAST_SPECIAL_EN
              if (div0_in || ovf_in) begin
                state_reg <= DONE;
                done      <= 1'b1;
                result    <= div_fix(is_rem, 1'b0, 1'b0, div0_in, ovf_in,
                                     32'd0, 32'd0, a);
              end else begin
                state_reg <= CALC;
              end
`else
              state_reg <= CALC;
`endif
            end
          end
          CALC: begin
            rem_reg <= rem_next;
            dvd_reg <= quo_next;
            if (cnt_reg == 5'd0) begin
              state_reg <= DONE;
              done      <= 1'b1;
              result    <= div_fix(is_rem_reg, neg_q_reg, neg_r_reg, div0_reg,
                                   ovf_reg, quo_next, rem_next, a_reg);
            end else begin
              cnt_reg <= cnt_reg - 5'd1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit_iter.sv
// Scoreboard bench for div_unit_iter: directed RISC-V corner cases, kill/reset
// behaviour and randomized operations checked against an arithmetic model.
module tb_div_unit_iter;
  import rv32_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  func3 = F3_DIVU;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_res = 32'd0;

  div_unit_iter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V M semantics computed directly with integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    logic        ovf;
    logic [31:0] r;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r   = 32'd0;
    case (f3)
      F3_DIV:  r = (y == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sx / sy));
      F3_REM:  r = (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
      F3_DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y, input bit track);
    exp_t e;
    bit   special;
    int   n;
    wait_idle(n);
    start   = 1'b1;
    func3   = f3;
    a       = x;
    b       = y;
    special = (y == 32'd0) ||
              (((f3 == F3_DIV) || (f3 == F3_REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF));
    e.res   = ref_div(f3, x, y);
    e.cyc   = cyc + ((FAST && special) ? 1 : 33);
    if (track) begin
      sb_q.push_back(e);
      last_res = e.res;
    end
    $display("[TB] issue f3=%0d a=%h b=%h expect=%h track=%0d", f3, x, y, e.res, track);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int          n;
    logic [2:0]  f3;
    logic [31:0] x;
    logic [31:0] y;

    fork
      begin
        exp_t m;
        forever begin
          @(negedge clk);
          if (rst && done) begin
            if (sb_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL spurious_done: result=%h with no request outstanding", result);
            end else begin
              m = sb_q.pop_front();
              chk("result", result, m.res);
              chk("done_cycle", 32'(cyc), 32'(m.cyc));
            end
          end
        end
      end
    join_none

    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(F3_DIVU, 32'd100, 32'd7, 1'b1);
    wait_idle(n);
    chk("busy_cycles_divu", 32'(n), 32'd33);
    issue(F3_REMU, 32'd100, 32'd7, 1'b1);
    issue(F3_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1);
    issue(F3_REM, 32'hFFFF_FF9C, 32'd7, 1'b1);
    issue(F3_DIV, 32'h1234_5678, 32'd0, 1'b1);
    wait_idle(n);
    chk("busy_cycles_div0", 32'(n), FAST ? 32'd1 : 32'd33);
    issue(F3_DIVU, 32'h1234_5678, 32'd0, 1'b1);
    issue(F3_REM, 32'h1234_5678, 32'd0, 1'b1);
    issue(F3_REMU, 32'h1234_5678, 32'd0, 1'b1);
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_idle(n);

    // Flush in the middle of a divide: no done, result untouched.
    issue(F3_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_result_hold", result, last_res);
    issue(F3_DIV, 32'hFFFF_F000, 32'd9, 1'b1);
    wait_idle(n);

    // kill beats start in IDLE.
    start = 1'b1;
    kill  = 1'b1;
    func3 = F3_DIVU;
    a     = 32'd50;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    chk("kill_start_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-operation.
    issue(F3_REM, 32'h7654_3210, 32'd13, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    issue(F3_REMU, 32'hFFFF_FFFF, 32'd10, 1'b1);

    for (int i = 0; i < 150; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      x  = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      issue(f3, x, y, 1'b1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit_iter.md
# div_unit_iter

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the ALU and feeds the EX result mux, replacing the single-cycle combinational divide path. While it is busy it stalls IF/ID/EX, and it returns a result on a one-cycle done strobe. Multiply stays in the ALU.

## Interface
- Parameters: none; the width is fixed at 32 bits.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset; clears all state and outputs.
- `start` in 1: request a divide; sampled only in IDLE.
- `func3` in 3: operation select; 4 = DIV, 5 = DIVU, 6 = REM, 7 = REMU; values 0–3 are never presented with `start`.
- `a` in 32: dividend (rs1).
- `b` in 32: divisor (rs2).
- `kill` in 1: pipeline flush; aborts any operation in flight.
- `busy` out 1: high whenever state != IDLE; drives the pipeline stall.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: quotient or remainder; holds its last value until the next `done`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `start`; latches `func3`, |a|, |b|, and the signs (signed ops only).
  - CALC runs 32 iterations, indexed by a 5-bit counter from 31 down to 0. Each iteration: remainder = {remainder[30:0], dividend MSB}; subtract the divisor; restore if the result is negative; shift the quotient bit in.
  - CALC → DONE after iteration 0.
  - DONE: `done` = 1, `result` is driven; the next state is IDLE unconditionally.
- Sign fix, applied when `result` is written:
  - Quotient is negated if sign(a) ≠ sign(b).
  - Remainder takes the sign of a.
- Special cases follow the RISC-V M spec exactly:
  - Divisor 0: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- `start` is ignored while `busy`. `start` asserted in the same cycle as DONE is not accepted; it must be presented again in IDLE.
- `kill` in any state → IDLE on the next edge; no `done` is produced and `result` is unchanged. `kill` and `start` together in IDLE: `kill` wins.
- All arithmetic is 32-bit unsigned on magnitudes; the trial subtraction uses a 33-bit compare.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0, state = IDLE, counter = 0.
- `start` sampled at edge E0; CALC occupies cycles E0+1 … E0+32; `done` is high in cycle E0+33.
- `busy` is high from E0+1 through E0+33 inclusive; it is low again from E0+34.
- Back-to-back throughput: one divide per 34 cycles.
- Reset mid-operation clears the unit immediately (asynchronous) with no `done`.
- Outputs are registered; there is no combinational path from the inputs to `busy`, `done` or `result`.

## Configuration
- `DIV_FAST_SPECIAL_EN`
  - Defined: divisor-0 and signed-overflow cases go IDLE → DONE directly, skipping CALC; `done` is high at E0+1.
  - Undefined: these cases run the full 32 iterations, and the DONE-stage override forces the same spec values at E0+33.
- Result values are identical in both builds; only latency differs.

## Structure
- Shared package `rv32_pkg`:
  - func3 localparams `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`.
  - State enum encoding: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Constant `DIV_ITERS` = 32.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: remainder, divisor, next dividend bit.
  - Outputs: new remainder, quotient bit.
- The FSM, counter and sign fix stay in `div_unit_iter`.

## Test plan
- DIVU a = 100, b = 7 → `done` at E0+33, `result` = 14; REMU with the same operands → `result` = 2; `busy` high for exactly 33 cycles.
- DIV a = −100 (0xFFFFFF9C), b = 7 → `result` = 0xFFFFFFF2 (−14); REM with the same operands → 0xFFFFFFFE (−2).
- Divide by zero, a = 0x12345678, b = 0 → DIV/DIVU give 0xFFFFFFFF, REM/REMU give 0x12345678. `done` at E0+1 with `DIV_FAST_SPECIAL_EN` defined, at E0+33 without it.
- DIV a = 0x80000000, b = 0xFFFFFFFF → `result` = 0x80000000; REM with the same operands → 0.
- `kill` at E0+10 → `busy` low at E0+11, no `done` pulse, `result` holds its prior value. A new `start` at E0+12 completes normally at E0+45.
- Assert `rst` low at E0+5 → `busy`, `done` and `result` read 0 immediately, and `start` is accepted right after `rst` is released.
